// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that steers NUM_REQ valid/ready producers onto one shared channel.
// A grant is held for a whole burst, which ends on req_last or after MAX_HOLD transferred beats.
module rr_mux_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_HOLD   = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [NUM_REQ-1:0]            grant_onehot,
    output logic [$clog2(NUM_REQ)-1:0]    grant_index,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Handshake: a beat moves when out_valid && out_ready; req_ready[g] is out_ready
    // forwarded to the owner only, so the owner sees exactly the same transfer condition.

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                 busy_q, busy_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;

    logic                 mux_valid;
    logic                 mux_last;
    logic [DATA_WIDTH-1:0] mux_data;
    logic                 in_burst;
    logic                 hold_last;
    logic                 xfer;

    // Rotating-priority search: start just after the previous owner and wrap around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        mux_valid = 1'b0;
        mux_last  = 1'b0;
        mux_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh_q[i]) begin
                mux_valid = req_valid[i];
                mux_last  = req_last[i];
                mux_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_burst  = (state_q == BURST);
    assign hold_last = (beat_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        req_ready = '0;
        if (in_burst) begin
            out_valid = mux_valid;
            out_last  = mux_last | hold_last;
            out_data  = mux_data;
            req_ready = grant_oh_q & {NUM_REQ{out_ready}};
        end
    end

    assign xfer = out_valid & out_ready;

    // Only transferred beats advance beat_cnt; stalls and bubbles hold the grant indefinitely.
    always_comb begin
        state_d      = state_q;
        grant_oh_d   = grant_oh_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = BURST;
                    grant_idx_d = pick_idx;
                    grant_oh_d  = NUM_REQ'(1) << pick_idx;
                    beat_cnt_d  = '0;
                    busy_d      = 1'b1;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (out_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_idx_q;
                        grant_oh_d   = '0;
                        grant_idx_d  = '0;
                        beat_cnt_d   = '0;
                        busy_d       = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                grant_oh_d  = '0;
                grant_idx_d = '0;
                beat_cnt_d  = '0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_oh_q   <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_oh_q   <= grant_oh_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign grant_onehot = grant_oh_q;
    assign grant_index  = grant_idx_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_HOLD=4).
// Each record gives one cycle of inputs and the outputs expected during that cycle.
module tb_rr_mux_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MH = 4;

    logic            clock;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic [NR-1:0]   grant_onehot;
    logic [1:0]      grant_index;
    logic            busy;

    int checks;
    int errors;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        ready;
        logic [3:0]  e_goh;
        logic        e_busy;
        logic        e_ov;
        logic        e_ol;
        logic [7:0]  e_od;
        logic [3:0]  e_rdy;
    } vec_t;

    vec_t vecs[20];

    rr_mux_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_HOLD  (MH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .grant_onehot(grant_onehot),
        .grant_index (grant_index),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(logic rst_n, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                                logic rdy, logic [3:0] goh, logic bsy, logic ov, logic ol,
                                logic [7:0] od, logic [3:0] erdy);
        vec_t r;
        r.rst_n = rst_n; r.valid = v; r.last = l; r.data = d; r.ready = rdy;
        r.e_goh = goh; r.e_busy = bsy; r.e_ov = ov; r.e_ol = ol; r.e_od = od; r.e_rdy = erdy;
        return r;
    endfunction

    function automatic logic [1:0] oh2idx(logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, check 1 ns later, well away from the rising edge.
    task automatic apply_vec(input string tag, input vec_t v);
        @(negedge clock);
        reset_n   = v.rst_n;
        req_valid = v.valid;
        req_last  = v.last;
        req_data  = v.data;
        out_ready = v.ready;
        #1;
        chk({tag, " grant_onehot"}, 32'(grant_onehot), 32'(v.e_goh));
        chk({tag, " grant_index"},  32'(grant_index),  32'(oh2idx(v.e_goh)));
        chk({tag, " busy"},         32'(busy),         32'(v.e_busy));
        chk({tag, " out_valid"},    32'(out_valid),    32'(v.e_ov));
        chk({tag, " out_last"},     32'(out_last),     32'(v.e_ol));
        chk({tag, " out_data"},     32'(out_data),     32'(v.e_od));
        chk({tag, " req_ready"},    32'(req_ready),    32'(v.e_rdy));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // Reset, then requester 2 sends A1,A2,A3 with last on the third beat.
        vecs[0]  = mk(0, 4'b0000, 4'b0000, 32'h0,          0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
        vecs[1]  = mk(1, 4'b0100, 4'b0000, 32'h00A1_0000,  1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
        vecs[2]  = mk(1, 4'b0100, 4'b0000, 32'h00A1_0000,  1, 4'b0100, 1, 1, 0, 8'hA1, 4'b0100);
        vecs[3]  = mk(1, 4'b0100, 4'b0000, 32'h00A2_0000,  1, 4'b0100, 1, 1, 0, 8'hA2, 4'b0100);
        vecs[4]  = mk(1, 4'b0100, 4'b0100, 32'h00A3_0000,  1, 4'b0100, 1, 1, 1, 8'hA3, 4'b0100);
        vecs[5]  = mk(1, 4'b0000, 4'b0000, 32'h0,          1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
        // Reset, then all four requesters with single-beat bursts: order 0,1,2,3,0,1.
        vecs[6]  = mk(0, 4'b0000, 4'b0000, 32'h0,          1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
        vecs[7]  = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
        vecs[8]  = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0001, 1, 1, 1, 8'h10, 4'b0001);
        vecs[9]  = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
        vecs[10] = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0010, 1, 1, 1, 8'h11, 4'b0010);
        vecs[11] = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
        vecs[12] = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0100, 1, 1, 1, 8'h12, 4'b0100);
        vecs[13] = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
        vecs[14] = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b1000, 1, 1, 1, 8'h13, 4'b1000);
        vecs[15] = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
        vecs[16] = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0001, 1, 1, 1, 8'h10, 4'b0001);
        vecs[17] = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);
        vecs[18] = mk(1, 4'b1111, 4'b1111, 32'h1312_1110,  1, 4'b0010, 1, 1, 1, 8'h11, 4'b0010);
        vecs[19] = mk(1, 4'b0000, 4'b0000, 32'h0,          1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000);

        for (int i = 0; i < 20; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

        // Forced release: requester 1 streams without last, requester 3 waits with one beat.
        apply_vec("hold0",  mk(0, 4'b0000, 4'b0000, 32'h0,         1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
        apply_vec("hold1",  mk(1, 4'b1010, 4'b1000, 32'hC000_5100, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
        apply_vec("hold2",  mk(1, 4'b1010, 4'b1000, 32'hC000_5100, 1, 4'b0010, 1, 1, 0, 8'h51, 4'b0010));
        apply_vec("hold3",  mk(1, 4'b1010, 4'b1000, 32'hC000_5200, 1, 4'b0010, 1, 1, 0, 8'h52, 4'b0010));
        apply_vec("hold4",  mk(1, 4'b1010, 4'b1000, 32'hC000_5300, 1, 4'b0010, 1, 1, 0, 8'h53, 4'b0010));
        apply_vec("hold5",  mk(1, 4'b1010, 4'b1000, 32'hC000_5400, 1, 4'b0010, 1, 1, 1, 8'h54, 4'b0010));
        apply_vec("hold6",  mk(1, 4'b1010, 4'b1000, 32'hC000_5500, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
        apply_vec("hold7",  mk(1, 4'b1010, 4'b1000, 32'hC000_5500, 1, 4'b1000, 1, 1, 1, 8'hC0, 4'b1000));
        apply_vec("hold8",  mk(1, 4'b0010, 4'b0000, 32'h0000_5500, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
        apply_vec("hold9",  mk(1, 4'b0010, 4'b0000, 32'h0000_5500, 1, 4'b0010, 1, 1, 0, 8'h55, 4'b0010));
        apply_vec("hold10", mk(1, 4'b0000, 4'b0000, 32'h0,         1, 4'b0010, 1, 0, 0, 8'h00, 4'b0010));

        // Backpressure and bubbles on requester 0; out_last must land on the 4th transferred beat.
        apply_vec("bp0", mk(0, 4'b0000, 4'b0000, 32'h0,    1, 4'b0010, 1, 0, 0, 8'h00, 4'b0010));
        apply_vec("bp1", mk(1, 4'b0001, 4'b0000, 32'h00D1, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
        apply_vec("bp2", mk(1, 4'b0001, 4'b0000, 32'h00D1, 1, 4'b0001, 1, 1, 0, 8'hD1, 4'b0001));
        apply_vec("bp3", mk(1, 4'b0001, 4'b0000, 32'h00D2, 0, 4'b0001, 1, 1, 0, 8'hD2, 4'b0000));
        apply_vec("bp4", mk(1, 4'b0001, 4'b0000, 32'h00D2, 1, 4'b0001, 1, 1, 0, 8'hD2, 4'b0001));
        apply_vec("bp5", mk(1, 4'b0000, 4'b0000, 32'h00D3, 1, 4'b0001, 1, 0, 0, 8'hD3, 4'b0001));
        apply_vec("bp6", mk(1, 4'b0000, 4'b0000, 32'h00D3, 1, 4'b0001, 1, 0, 0, 8'hD3, 4'b0001));
        apply_vec("bp7", mk(1, 4'b0001, 4'b0000, 32'h00D3, 1, 4'b0001, 1, 1, 0, 8'hD3, 4'b0001));
        apply_vec("bp8", mk(1, 4'b0001, 4'b0000, 32'h00D4, 1, 4'b0001, 1, 1, 1, 8'hD4, 4'b0001));
        apply_vec("bp9", mk(1, 4'b0000, 4'b0000, 32'h0,    1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));

        // Reset during beat 2 of requester 2's burst; priority pointer returns to requester 0.
        apply_vec("rst0", mk(1, 4'b0100, 4'b0000, 32'h00E1_0000, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
        apply_vec("rst1", mk(1, 4'b0100, 4'b0000, 32'h00E1_0000, 1, 4'b0100, 1, 1, 0, 8'hE1, 4'b0100));
        apply_vec("rst2", mk(0, 4'b0100, 4'b0000, 32'h00E2_0000, 1, 4'b0100, 1, 1, 0, 8'hE2, 4'b0100));
        apply_vec("rst3", mk(1, 4'b0101, 4'b0001, 32'h00E3_00F0, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
        apply_vec("rst4", mk(1, 4'b0101, 4'b0001, 32'h00E3_00F0, 1, 4'b0001, 1, 1, 1, 8'hF0, 4'b0001));
        apply_vec("rst5", mk(1, 4'b0000, 4'b0000, 32'h0,         1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares a single DATA_WIDTH output channel among NUM_REQ requesters.
- The shared channel is a mux steered by a registered grant.
- A grant is held for a whole burst, which ends on `last` or on a hold-limit timeout.
- Sits between multiple producer blocks and one consumer; all transfers use valid/ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, width of each data beat.
- MAX_HOLD, 16, maximum beats per grant before forced release (1..255).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  per-requester end-of-burst flag.
- req_ready  output  NUM_REQ  per-requester beat accepted.
- out_valid  output  1  shared channel valid.
- out_data  output  DATA_WIDTH  shared channel data.
- out_last  output  1  shared channel end-of-burst (includes forced release).
- out_ready  input  1  consumer ready.
- grant_onehot  output  NUM_REQ  current owner, one-hot; all zero when idle.
- grant_index  output  $clog2(NUM_REQ)  encoded owner; 0 when idle.
- busy  output  1  high while in BURST.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE, grant_onehot=0, grant_index=0, beat_cnt=0, busy=0.
  - Priority pointer last_grant=NUM_REQ-1, so requester 0 wins first.
  - Combinational outputs resolve to out_valid=0, out_last=0, req_ready=0, out_data=0.
- FSM states: IDLE, BURST.
- IDLE:
  - req_ready all 0; out_valid=0.
  - If any req_valid is high, select the first requester with valid high, searching from last_grant+1 upward with wrap modulo NUM_REQ.
  - Register the grant and move to BURST. Arbitration latency is 1 cycle: a request seen in cycle t can transfer no earlier than cycle t+1.
  - If no req_valid is high, stay in IDLE.
- BURST with grant g:
  - out_valid=req_valid[g]; out_data=req_data[g]; req_ready[g]=out_ready; all other req_ready=0. Data path is combinational, with zero added latency.
  - out_last = req_last[g] OR (beat_cnt == MAX_HOLD-1).
  - A beat transfers when out_valid AND out_ready. On each transfer, beat_cnt increments.
  - A transfer with out_last high ends the burst: last_grant←g, beat_cnt←0, grant cleared, return to IDLE.
  - Back-to-back grants to different requesters therefore have exactly one idle cycle between them.
- Owner deasserts req_valid mid-burst: the grant is held and the channel bubbles. There is no timeout on stall cycles; only transferred beats count toward MAX_HOLD.
- Forced release at MAX_HOLD:
  - out_last is asserted on beat MAX_HOLD even if req_last[g]=0.
  - The requester keeps its remaining beats and re-arbitrates.
  - Round-robin means other waiting requesters are served first.
- Simultaneous requests in IDLE: exactly one grant, chosen by the rotating priority above. Never more than one bit set in grant_onehot or req_ready.
- Non-owners requesting during a burst: they wait, with req_ready=0. Their request stays pending; valid is expected to stay high, per the standard valid/ready rule.
- Reset mid-burst: takes effect at the next edge regardless of state. A partially sent burst is abandoned; the consumer sees out_valid drop.
- MAX_HOLD=1: every beat is a burst of one, and out_last is always high in BURST.
- beat_cnt width is $clog2(MAX_HOLD+1) and never wraps, because the burst ends at MAX_HOLD.

Test Plan:
- Reset then single requester: NUM_REQ=4. Requester 2 sends 3 beats 0xA1,0xA2,0xA3 with last on the 3rd and out_ready=1.
  - Expect grant_onehot=4'b0100 one cycle after valid.
  - out_data shows A1,A2,A3 on consecutive cycles, with out_last on A3.
  - Then IDLE, with grant_onehot=0.
- All four requesters valid continuously with 1-beat bursts (last=1):
  - Grant order is 0,1,2,3,0,1.
  - Each grant is separated by one idle cycle; 6 beats take 12 cycles.
- Forced release: MAX_HOLD=4. Requester 1 streams 10 beats with no last while requester 3 is also valid.
  - out_last is high on beat 4; requester 3 is granted next.
  - Requester 1 then resumes with beat 5.
- Backpressure and bubbles during requester 0's burst:
  - out_ready toggles 1,0,1 and req_valid[0] drops for 2 cycles.
  - No beat is lost or duplicated, and req_ready[0] mirrors out_ready.
  - Grant stays 0001 throughout, and beat_cnt counts only transferred beats.
- Reset mid-burst: assert reset_n=0 for one cycle during beat 2 of a 5-beat burst from requester 2.
  - Next cycle, all outputs are 0 and state is IDLE.
  - With requesters 0 and 2 both valid, requester 0 is granted first.
